// File: rtl/mem_merge_arb.sv
// N-master to 1-slave merge for the native valid/ready memory bus.
// Registered grant; IDLE doubles as the mandatory turnaround cycle between transactions.
module mem_merge_arb #(
  parameter  int N_MASTERS = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 256,
  parameter  int ARB_MODE  = 1,
  localparam int GW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int SW        = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MASTERS-1:0]     m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [N_MASTERS*SW-1:0]  m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0] m_rdata,
  output logic [N_MASTERS-1:0]     m_ready,
  output logic                     s_valid,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  output logic [SW-1:0]            s_wstrb,
  input  logic [DATA_W-1:0]        s_rdata,
  input  logic                     s_ready,
  output logic [GW-1:0]            grant_id
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, nxt;
  logic [GW-1:0] grant, rr_ptr, win;
  logic          found, busy;
  int            idx;

  assign busy = (state == BUSY);

  // Search starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (ARB_MODE == 1) ? int'(rr_ptr) + k : k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!found && m_valid[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (found)   nxt = BUSY;
      BUSY:    if (s_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && found) grant <= win;
      if (busy && s_ready && ARB_MODE == 1)
        rr_ptr <= (grant == GW'(N_MASTERS - 1)) ? '0 : grant + GW'(1);
    end
  end

  assign grant_id = grant;
  assign s_valid  = busy;
  assign s_addr   = busy ? m_addr[int'(grant)*ADDR_W +: ADDR_W]  : '0;
  assign s_wdata  = busy ? m_wdata[int'(grant)*DATA_W +: DATA_W] : '0;
  assign s_wstrb  = busy ? m_wstrb[int'(grant)*SW +: SW]         : '0;

  // Per-master return path: only the granted lane sees the slave response.
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
    logic sel;
    assign sel                      = busy && (grant == GW'(i));
    assign m_ready[i]               = sel && s_ready;
    assign m_rdata[i*DATA_W +: DATA_W] = sel ? s_rdata : '0;
  end

endmodule

// File: tb/tb_mem_merge_arb.sv
// Directed vector bench: round-robin instance driven from a table, fixed-priority instance by hand.
module tb_mem_merge_arb;
  localparam int N = 4, AW = 32, DW = 32, SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, srdy;
  logic [N-1:0]      mv, fmv;
  logic [N*AW-1:0]   maddr;
  logic [N*DW-1:0]   mwdata;
  logic [N*SW-1:0]   mwstrb;
  logic [DW-1:0]     srdata;

  logic [N*DW-1:0] r_rdata, f_rdata;
  logic [N-1:0]    r_mready, f_mready;
  logic            r_sv, f_sv;
  logic [AW-1:0]   r_saddr, f_saddr;
  logic [DW-1:0]   r_swdata, f_swdata;
  logic [SW-1:0]   r_swstrb, f_swstrb;
  logic [1:0]      r_gid, f_gid;

  mem_merge_arb #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .m_valid(mv), .m_addr(maddr), .m_wdata(mwdata), .m_wstrb(mwstrb),
    .m_rdata(r_rdata), .m_ready(r_mready), .s_valid(r_sv), .s_addr(r_saddr), .s_wdata(r_swdata),
    .s_wstrb(r_swstrb), .s_rdata(srdata), .s_ready(srdy), .grant_id(r_gid));

  mem_merge_arb #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .m_valid(fmv), .m_addr(maddr), .m_wdata(mwdata), .m_wstrb(mwstrb),
    .m_rdata(f_rdata), .m_ready(f_mready), .s_valid(f_sv), .s_addr(f_saddr), .s_wdata(f_swdata),
    .s_wstrb(f_swstrb), .s_rdata(srdata), .s_ready(srdy), .grant_id(f_gid));

  typedef struct {
    logic          rst;
    logic [3:0]    mv;
    logic          srdy;
    logic          sv;
    logic [1:0]    gid;
    logic [3:0]    mr;
    logic [31:0]   addr;
  } vec_t;

  int vectors = 0, miscompares = 0;
  vec_t tbl[35];

  function automatic vec_t v(logic r, logic [3:0] m, logic s, logic esv, logic [1:0] eg,
                             logic [3:0] emr, logic [31:0] ea);
    vec_t x;
    x.rst = r; x.mv = m; x.srdy = s; x.sv = esv; x.gid = eg; x.mr = emr; x.addr = ea;
    return x;
  endfunction

  task automatic chk(input string name, input int row, input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(int i);
    logic [N*AW-1:0] a;
    a = maddr;
    return a[i*AW +: AW];
  endfunction

  initial begin
    logic [31:0]   ewd;
    logic [3:0]    ews;
    logic [127:0]  erd;
    maddr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0040};
    mwdata = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'h1234_5678};
    mwstrb = {4'h0, 4'h0, 4'h0, 4'hF};
    srdata = 32'hA5A5_A5A5;
    rst = 1'b1; mv = '0; fmv = '0; srdy = 1'b0;

    // single read on master 1
    tbl[0]  = v(0, 4'b0010, 0, 0, 2'd0, 4'b0000, 32'h0);
    tbl[1]  = v(0, 4'b0010, 0, 1, 2'd1, 4'b0000, 32'h1000);
    tbl[2]  = v(0, 4'b0010, 0, 1, 2'd1, 4'b0000, 32'h1000);
    tbl[3]  = v(0, 4'b0010, 1, 1, 2'd1, 4'b0010, 32'h1000);
    tbl[4]  = v(0, 4'b0000, 0, 0, 2'd1, 4'b0000, 32'h0);
    // spurious s_ready while idle
    tbl[5]  = v(0, 4'b0000, 1, 0, 2'd1, 4'b0000, 32'h0);
    tbl[6]  = v(0, 4'b0000, 0, 0, 2'd1, 4'b0000, 32'h0);
    // all request, rr_ptr = 2: grants 2,3,0,1
    tbl[7]  = v(0, 4'b1111, 0, 0, 2'd1, 4'b0000, 32'h0);
    tbl[8]  = v(0, 4'b1111, 0, 1, 2'd2, 4'b0000, 32'h2000);
    tbl[9]  = v(0, 4'b1111, 1, 1, 2'd2, 4'b0100, 32'h2000);
    tbl[10] = v(0, 4'b1111, 0, 0, 2'd2, 4'b0000, 32'h0);
    tbl[11] = v(0, 4'b1111, 0, 1, 2'd3, 4'b0000, 32'h3000);
    tbl[12] = v(0, 4'b1111, 1, 1, 2'd3, 4'b1000, 32'h3000);
    tbl[13] = v(0, 4'b1111, 0, 0, 2'd3, 4'b0000, 32'h0);
    tbl[14] = v(0, 4'b1111, 0, 1, 2'd0, 4'b0000, 32'h40);
    tbl[15] = v(0, 4'b1111, 1, 1, 2'd0, 4'b0001, 32'h40);
    tbl[16] = v(0, 4'b1111, 0, 0, 2'd0, 4'b0000, 32'h0);
    tbl[17] = v(0, 4'b1111, 0, 1, 2'd1, 4'b0000, 32'h1000);
    tbl[18] = v(0, 4'b1111, 1, 1, 2'd1, 4'b0010, 32'h1000);
    tbl[19] = v(0, 4'b0000, 0, 0, 2'd1, 4'b0000, 32'h0);
    // reset while busy on master 2, then rr_ptr must restart at 0
    tbl[20] = v(0, 4'b0100, 0, 0, 2'd1, 4'b0000, 32'h0);
    tbl[21] = v(1, 4'b0100, 0, 1, 2'd2, 4'b0000, 32'h2000);
    tbl[22] = v(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 32'h0);
    tbl[23] = v(0, 4'b0101, 0, 0, 2'd0, 4'b0000, 32'h0);
    tbl[24] = v(0, 4'b0101, 0, 1, 2'd0, 4'b0000, 32'h40);
    tbl[25] = v(0, 4'b0101, 1, 1, 2'd0, 4'b0001, 32'h40);
    tbl[26] = v(0, 4'b0100, 0, 0, 2'd0, 4'b0000, 32'h0);
    tbl[27] = v(0, 4'b0100, 1, 1, 2'd2, 4'b0100, 32'h2000);
    tbl[28] = v(0, 4'b0000, 0, 0, 2'd2, 4'b0000, 32'h0);
    // granted master drops valid mid-transaction; rr_ptr then wraps 3 -> 0
    tbl[29] = v(0, 4'b1000, 0, 0, 2'd2, 4'b0000, 32'h0);
    tbl[30] = v(0, 4'b0000, 0, 1, 2'd3, 4'b0000, 32'h3000);
    tbl[31] = v(0, 4'b0000, 1, 1, 2'd3, 4'b1000, 32'h3000);
    tbl[32] = v(0, 4'b0000, 0, 0, 2'd3, 4'b0000, 32'h0);
    tbl[33] = v(0, 4'b0011, 0, 0, 2'd3, 4'b0000, 32'h0);
    tbl[34] = v(0, 4'b0011, 0, 1, 2'd0, 4'b0000, 32'h40);

    repeat (2) @(posedge clk);

    for (int r = 0; r < 35; r++) begin
      @(negedge clk);
      rst = tbl[r].rst; mv = tbl[r].mv; srdy = tbl[r].srdy;
      #1;
      vectors++;
      ewd = '0; ews = '0; erd = '0;
      if (tbl[r].sv) begin
        ewd = (tbl[r].gid == 2'd0) ? 32'h1234_5678 : {28'hD00_0000, 2'b00, tbl[r].gid};
        ews = (tbl[r].gid == 2'd0) ? 4'hF : 4'h0;
        erd[int'(tbl[r].gid)*DW +: DW] = 32'hA5A5_A5A5;
      end
      chk("s_valid",  r, 128'(r_sv),     128'(tbl[r].sv));
      chk("grant_id", r, 128'(r_gid),    128'(tbl[r].gid));
      chk("m_ready",  r, 128'(r_mready), 128'(tbl[r].mr));
      chk("s_addr",   r, 128'(r_saddr),  128'(tbl[r].addr));
      chk("s_wdata",  r, 128'(r_swdata), 128'(ewd));
      chk("s_wstrb",  r, 128'(r_swstrb), 128'(ews));
      chk("m_rdata",  r, r_rdata,        erd);
    end

    // fixed priority: master 1 wins repeatedly over master 3 until it drops
    mv = '0; rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      fmv  = (k < 6) ? 4'b1010 : 4'b1000;
      srdy = 1'b1;
      #1;
      vectors++;
      chk("fp_s_valid", 100 + k, 128'(f_sv), 128'(k % 2));
      if (k % 2 == 1) begin
        chk("fp_grant",   100 + k, 128'(f_gid),    (k < 6) ? 128'd1 : 128'd3);
        chk("fp_m_ready", 100 + k, 128'(f_mready), (k < 6) ? 128'b0010 : 128'b1000);
        chk("fp_s_addr",  100 + k, 128'(f_saddr),  128'(addr_of((k < 6) ? 1 : 3)));
      end else begin
        chk("fp_m_ready", 100 + k, 128'(f_mready), 128'd0);
      end
      if (k == 5) fmv = 4'b1000;
    end
    @(negedge clk);
    fmv = '0; srdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_merge_arb.md
Name: mem_merge_arb

Overview:
- Parametrised N-master to 1-slave merge for the native valid/ready memory bus (valid, addr, wdata, wstrb, rdata, ready).
- Sits between the L1 cache back-ends (icache, dcache, accelerator DMA ports) and the shared L2 cache front-end on the MIG-width bus.
- Generalises the fixed two-master merge:
  - any master count;
  - selectable fixed-priority or round-robin arbitration;
  - registered grant, with a guaranteed turnaround cycle between transactions.

Parameters:
- N_MASTERS, 2, number of master ports (>=1).
- ADDR_W, 32, byte address width forwarded unchanged.
- DATA_W, 256, data width (MIG bus width); multiple of 8.
- ARB_MODE, 1, 0 = fixed priority (master 0 highest), 1 = round-robin.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- m_valid  in  N_MASTERS  per-master request valid.
- m_addr  in  N_MASTERS*ADDR_W  per-master address; master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  per-master write data.
- m_wstrb  in  N_MASTERS*DATA_W/8  per-master byte strobes; all-zero means read.
- m_rdata  out  N_MASTERS*DATA_W  per-master read data.
- m_ready  out  N_MASTERS  per-master completion pulse.
- s_valid  out  1  slave request valid.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_wstrb  out  DATA_W/8  slave strobes.
- s_rdata  in  DATA_W  slave read data, valid with s_ready.
- s_ready  in  1  slave completion pulse.
- grant_id  out  max(1,$clog2(N_MASTERS))  index of the current or last granted master (debug/perf).

Behaviour:
- Interface and reset:
  - Single clock domain.
  - Reset synchronous, active-high, on rst sampled at posedge clk.
  - Reset values: state=IDLE, s_valid=0, m_ready=0, rr_ptr=0, grant_id=0, grant register=0.
  - s_addr/s_wdata/s_wstrb drive 0 while s_valid=0.
- States: IDLE, BUSY. Two states are sufficient; the turnaround cycle is IDLE itself.
- IDLE:
  - If any m_valid bit is set, select winner W and register grant=W, grant_id=W; go to BUSY next cycle.
  - Otherwise stay in IDLE.
- Arbitration:
  - ARB_MODE=0: W = lowest index with m_valid set.
  - ARB_MODE=1: W = first index with m_valid set, searching from rr_ptr upward and wrapping modulo N_MASTERS.
- BUSY:
  - s_valid=1.
  - s_addr/s_wdata/s_wstrb combinationally muxed from master grant.
  - Hold until s_ready=1.
- Completion cycle (BUSY and s_ready):
  - m_ready[grant]=1 for exactly this cycle; m_rdata[grant]=s_rdata in the same cycle.
  - Next state is IDLE.
  - ARB_MODE=1: rr_ptr <= (grant==N_MASTERS-1) ? 0 : grant+1.
- Latency:
  - Request accepted in IDLE at cycle t gives s_valid at t+1 (one-cycle arbitration).
  - s_ready at cycle c gives m_ready at c (zero added latency).
  - Next s_valid no earlier than c+2.
- Turnaround: the mandatory IDLE cycle lets a completed master deassert m_valid before re-arbitration, so one request is never serviced twice.
- m_ready bits never assert outside BUSY and s_ready; they are one-hot or zero.
- m_rdata:
  - Non-granted masters' m_rdata slices hold 0.
  - The granted slice equals s_rdata during BUSY, and 0 in IDLE.
- Boundary conditions:
  - Simultaneous requests: resolved per ARB_MODE; losers keep m_valid high and are served later.
  - Round-robin guarantees each requester service within N_MASTERS transactions.
  - Granted master drops m_valid mid-BUSY (protocol violation): s_valid stays 1 with currently muxed fields; completion still pulses m_ready[grant].
  - s_ready while IDLE: ignored, no m_ready.
  - rst during BUSY: next cycle IDLE, s_valid=0, no m_ready pulse, rr_ptr=0.
  - N_MASTERS=1: grant always 0, grant_id width 1, same IDLE/BUSY timing.
  - rr_ptr wraps from N_MASTERS-1 to 0.
- Arithmetic: grant and rr_ptr width max(1,$clog2(N_MASTERS)); no address or data modification.

Test Plan:
- Single read: N=2, ARB_MODE=1, master1 valid with addr=0x0000_1000, wstrb=0.
  - s_valid at +1 with s_addr=0x1000.
  - Slave answers s_ready with s_rdata=0xA5...A5 at +3 → m_ready=2'b10 and m_rdata[1]=0xA5...A5 in that cycle; s_valid=0 next cycle.
- Fixed priority: N=4, ARB_MODE=0, m_valid=4'b1010 held.
  - Grant order 1, 1, 1... while master 1 keeps requesting; master 3 only granted after master 1 deasserts.
- Round-robin fairness: N=4, ARB_MODE=1, m_valid=4'b1111 held, slave ready 2 cycles after each s_valid.
  - grant_id sequence 0,1,2,3,0.
  - Exactly one IDLE cycle between each s_ready and the next s_valid.
- Write pass-through: master0 wstrb=0xF..F, wdata=0x1234...
  - s_wstrb/s_wdata match exactly during BUSY; zero when IDLE.
- Reset mid-transaction: assert rst for 1 cycle while BUSY on master 2.
  - Next cycle s_valid=0, m_ready=0, grant_id=0.
  - A subsequent m_valid=4'b0100 is re-granted with rr_ptr starting at 0.
- Spurious s_ready in IDLE with all m_valid=0 → m_ready stays 0, state stays IDLE.
